game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Countdown timer that drives the game FSM's `timer_expired` input and consumes its `game_active` output.
- Loads the game duration when a round starts and decrements once per second from a prescaled 100 MHz clock.
- Pulses `timer_expired` when the count reaches zero.
- Exports remaining seconds in binary and BCD for the seven-segment display, plus a last-seconds warning flag.

Parameters:
- CLK_HZ, 100000000, clkIn cycles per game second (prescaler terminal count + 1); benches override with a small value.
- GAME_SECONDS, 30, round length in seconds; legal range 1..63.
- WARN_SECONDS, 5, warning asserted while 0 < seconds_left <= WARN_SECONDS during counting.

Ports:
- clkIn  input  1  100 MHz system clock.
- reset  input  1  asynchronous, active-low reset.
- game_active  input  1  level from game FSM; high while round is running.
- timer_expired  output  1  one-cycle pulse when countdown reaches 0.
- seconds_left  output  6  remaining seconds, binary.
- bcd_tens  output  4  tens digit of seconds_left.
- bcd_ones  output  4  ones digit of seconds_left.
- counting  output  1  high while in COUNT state.
- warning  output  1  last-seconds indicator.

Behaviour:
- Reset (async, active-low) values:
  - state = IDLE, prescaler = 0, seconds_left = GAME_SECONDS, bcd_tens/bcd_ones = digits of GAME_SECONDS.
  - timer_expired = 0, counting = 0, warning = 0.
  - Reset mid-count abandons the round immediately.
- All outputs are registered; no combinational path from inputs to outputs.
- Start detection: register game_active once (active_d). start = game_active & ~active_d.
- States:
  - IDLE.
    - start: load seconds_left = GAME_SECONDS, clear prescaler, go COUNT.
  - COUNT.
    - Prescaler increments each cycle.
    - At prescaler == CLK_HZ-1, prescaler wraps to 0 and seconds_left decrements by 1.
    - First decrement occurs exactly CLK_HZ cycles after the start edge.
    - If the decrement takes seconds_left from 1 to 0, assert timer_expired on that same edge and go EXPIRED.
    - If game_active is low, go IDLE, hold seconds_left, clear prescaler, no pulse.
  - EXPIRED.
    - seconds_left holds 0.
    - start: reload GAME_SECONDS, clear prescaler, go COUNT.
    - Otherwise remain; game_active may stay low indefinitely.
- timer_expired:
  - High for exactly one clkIn cycle per round, then 0 on the next edge.
  - Never asserted from IDLE or EXPIRED.
  - Never re-asserted while holding at 0.
- Start coincident with prescaler wrap: start wins; load takes priority over decrement.
- seconds_left never wraps below 0.
- counting = 1 exactly while state == COUNT.
- warning = counting & (seconds_left != 0) & (seconds_left <= WARN_SECONDS), registered.
- BCD digits are updated on the same edge as seconds_left.
  - bcd_tens = seconds_left / 10, bcd_ones = seconds_left % 10.
  - Implemented without a general divider, e.g. compare/subtract tens, valid for 0..63.
- Prescaler width = clog2(CLK_HZ); must hold CLK_HZ-1 without overflow.
- GAME_SECONDS = 1: timer_expired fires CLK_HZ cycles after start.

Test Plan:
- Reset (CLK_HZ=4, GAME_SECONDS=3) -> seconds_left=3, bcd=0/3, timer_expired=0, counting=0, warning=0.
- game_active rises at cycle 0 and is held high.
  - seconds_left reads 2 after cycle 4 and 1 after cycle 8.
  - 0 after cycle 12, with timer_expired high for exactly cycle 12 only.
  - counting drops at the same edge.
- GAME_SECONDS=30, CLK_HZ=2, full round -> bcd tens/ones track 30,29,...,10,09,...,00.
  - warning high for seconds_left 5..1, low at 0.
  - Exactly one timer_expired pulse.
- game_active drops at cycle 6 of the 3-second round -> IDLE, seconds_left holds 2, no pulse.
  - A new rise reloads 3 and restarts a full CLK_HZ interval.
- After expiry, game_active falls and rises again (FINISH->RUNNING) -> reload 3, second round pulses once.
  - Holding game_active low for 100 cycles in EXPIRED produces no pulse.
- Assert reset at cycle 5 of a round, release at cycle 7 -> all outputs at reset values.
  - With game_active still high, no restart until a fresh low-to-high edge is seen.

Source files
------------

// File: rtl/game_countdown_timer.sv
// Round countdown timer: loads GAME_SECONDS on a game_active rising edge, counts down
// once per CLK_HZ clocks, pulses timer_expired at zero and exports binary/BCD/warning.
module game_countdown_timer #(
    parameter int CLK_HZ       = 100000000,
    parameter int GAME_SECONDS = 30,
    parameter int WARN_SECONDS = 5
) (
    input  logic       clkIn,
    input  logic       reset,
    input  logic       game_active,
    output logic       timer_expired,
    output logic [5:0] seconds_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       counting,
    output logic       warning
);

    localparam int              PS_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(CLK_HZ - 1);
    localparam logic [5:0]      GAME_V   = 6'(GAME_SECONDS);
    localparam logic [5:0]      WARN_V   = 6'((WARN_SECONDS > 63) ? 63 : WARN_SECONDS);
    localparam logic [3:0]      RST_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]      RST_ONES = 4'(GAME_SECONDS % 10);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COUNT   = 2'd1;
    localparam logic [1:0] S_EXPIRED = 2'd2;

    logic [1:0]      r_state;
    logic [PS_W-1:0] r_prescale;
    logic            r_active_d;
    logic [5:0]      r_seconds;
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic            r_expired;
    logic            r_counting;
    logic            r_warning;

    logic            w_start;
    logic [1:0]      w_state_nxt;
    logic [PS_W-1:0] w_pre_nxt;
    logic [5:0]      w_sec_nxt;
    logic            w_exp_nxt;
    logic [5:0]      w_rem;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_nxt;
    logic            w_warn_nxt;

    assign w_start = game_active & ~r_active_d;

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_prescale;
        w_sec_nxt   = r_seconds;
        w_exp_nxt   = 1'b0;
        case (r_state)
            S_IDLE, S_EXPIRED: begin
                if (w_start) begin
                    w_state_nxt = S_COUNT;
                    w_pre_nxt   = '0;
                    w_sec_nxt   = GAME_V;
                end
            end
            S_COUNT: begin
                if (w_start) begin
                    w_pre_nxt = '0;
                    w_sec_nxt = GAME_V;
                end else if (!game_active) begin
                    w_state_nxt = S_IDLE;
                    w_pre_nxt   = '0;
                end else if (r_prescale == PS_MAX) begin
                    w_pre_nxt = '0;
                    if (r_seconds != 6'd0) w_sec_nxt = r_seconds - 6'd1;
                    if (r_seconds <= 6'd1) begin
                        w_state_nxt = S_EXPIRED;
                        w_exp_nxt   = 1'b1;
                    end
                end else begin
                    w_pre_nxt = r_prescale + PS_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pre_nxt   = '0;
            end
        endcase
    end

    // Repeated compare/subtract of ten; six passes cover 0..63.
    always_comb begin
        w_rem      = w_sec_nxt;
        w_tens_nxt = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (w_rem >= 6'd10) begin
                w_rem      = w_rem - 6'd10;
                w_tens_nxt = w_tens_nxt + 4'd1;
            end
        end
        w_ones_nxt = w_rem[3:0];
        w_warn_nxt = (w_state_nxt == S_COUNT) && (w_sec_nxt != 6'd0) && (w_sec_nxt <= WARN_V);
    end

    // active_d resets high so a level still high after reset is not taken as a new start.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_prescale <= '0;
            r_active_d <= 1'b1;
            r_seconds  <= GAME_V;
            r_tens     <= RST_TENS;
            r_ones     <= RST_ONES;
            r_expired  <= 1'b0;
            r_counting <= 1'b0;
            r_warning  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prescale <= w_pre_nxt;
            r_active_d <= game_active;
            r_seconds  <= w_sec_nxt;
            r_tens     <= w_tens_nxt;
            r_ones     <= w_ones_nxt;
            r_expired  <= w_exp_nxt;
            r_counting <= (w_state_nxt == S_COUNT);
            r_warning  <= w_warn_nxt;
        end
    end

    assign timer_expired = r_expired;
    assign seconds_left  = r_seconds;
    assign bcd_tens      = r_tens;
    assign bcd_ones      = r_ones;
    assign counting      = r_counting;
    assign warning       = r_warning;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench: a 3-second/4-clock timer for control flow and a 30-second/2-clock
// timer for the BCD and warning sequence.
module tb_game_countdown_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       act_a, act_b;
    logic       a_exp, a_cnt, a_warn, b_exp, b_cnt, b_warn;
    logic [5:0] a_sec, b_sec;
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic [16:0] obs_a, obs_b;

    logic [16:0] sb[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_countdown_timer #(.CLK_HZ(4), .GAME_SECONDS(3), .WARN_SECONDS(5)) u_a (
        .clkIn(clk), .reset(reset_n), .game_active(act_a),
        .timer_expired(a_exp), .seconds_left(a_sec), .bcd_tens(a_tens),
        .bcd_ones(a_ones), .counting(a_cnt), .warning(a_warn)
    );

    game_countdown_timer #(.CLK_HZ(2), .GAME_SECONDS(30), .WARN_SECONDS(5)) u_b (
        .clkIn(clk), .reset(reset_n), .game_active(act_b),
        .timer_expired(b_exp), .seconds_left(b_sec), .bcd_tens(b_tens),
        .bcd_ones(b_ones), .counting(b_cnt), .warning(b_warn)
    );

    assign obs_a = {a_exp, a_sec, a_tens, a_ones, a_cnt, a_warn};
    assign obs_b = {b_exp, b_sec, b_tens, b_ones, b_cnt, b_warn};

    function automatic logic [16:0] mk(input logic e, input int s, input logic c, input logic w);
        mk = {e, 6'(s), 4'(s / 10), 4'(s % 10), c, w};
    endfunction

    // Expected outputs of the 3 s / 4 clk timer, k clocks after the start edge.
    function automatic logic [16:0] round_a(input int k);
        int s;
        s = (k < 12) ? 3 - k / 4 : 0;
        round_a = mk(k == 12, s, k < 12, (k < 12) && (s > 0) && (s <= 5));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [16:0] w;
        reset_n = 1'b0;
        act_a   = 1'b0;
        act_b   = 1'b0;
        repeat (2) tick;
        sb.push_back(mk(0, 3, 0, 0));
        sb.push_back(mk(0, 30, 0, 0));
        w = sb.pop_front();
        total++;
        if (obs_a !== w) begin bad++; $display("FAIL reset_a got=%h want=%h", obs_a, w); end
        w = sb.pop_front();
        total++;
        if (obs_b !== w) begin bad++; $display("FAIL reset_b got=%h want=%h", obs_b, w); end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(0, 3, 0, 0));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL idle k=%0d got=%h want=%h", k, obs_a, w); end
        end
    endtask

    task automatic test_countdown(input string name);
        logic [16:0] w;
        int pulses = 0;
        act_a = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sb.push_back(round_a(k));
            tick;
            w = sb.pop_front();
            if (a_exp) pulses++;
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL %s k=%0d got=%h want=%h", name, k, obs_a, w); end
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL %s_pulses got=%0d want=1", name, pulses); end
    endtask

    task automatic test_expired_hold;
        logic [16:0] w;
        act_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            sb.push_back(mk(0, 0, 0, 0));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL hold k=%0d got=%h want=%h", k, obs_a, w); end
        end
    endtask

    task automatic test_abort;
        logic [16:0] w;
        act_a = 1'b0;
        repeat (2) tick;
        for (int k = 0; k < 12; k++) begin
            act_a = (k < 6);
            sb.push_back((k < 6) ? round_a(k) : mk(0, 2, 0, 0));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL abort k=%0d got=%h want=%h", k, obs_a, w); end
        end
        act_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(round_a(k));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL reload k=%0d got=%h want=%h", k, obs_a, w); end
        end
    endtask

    task automatic test_reset_midround;
        logic [16:0] w;
        act_a = 1'b0;
        sb.push_back(mk(0, 2, 0, 0));
        tick;
        w = sb.pop_front();
        total++;
        if (obs_a !== w) begin bad++; $display("FAIL drop got=%h want=%h", obs_a, w); end
        act_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(round_a(k));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL pre_reset k=%0d got=%h want=%h", k, obs_a, w); end
        end
        reset_n = 1'b0;
        #1;
        sb.push_back(mk(0, 3, 0, 0));
        w = sb.pop_front();
        total++;
        if (obs_a !== w) begin bad++; $display("FAIL async_reset got=%h want=%h", obs_a, w); end
        repeat (2) tick;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sb.push_back(mk(0, 3, 0, 0));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL no_restart k=%0d got=%h want=%h", k, obs_a, w); end
        end
        act_a = 1'b0;
        tick;
        act_a = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sb.push_back(round_a(k));
            tick;
            w = sb.pop_front();
            total++;
            if (obs_a !== w) begin bad++; $display("FAIL post_reset k=%0d got=%h want=%h", k, obs_a, w); end
        end
    endtask

    task automatic test_bcd;
        logic [16:0] w;
        int s;
        int pulses = 0;
        act_b = 1'b1;
        for (int k = 0; k < 64; k++) begin
            s = (k < 60) ? 30 - k / 2 : 0;
            sb.push_back(mk(k == 60, s, k < 60, (k < 60) && (s > 0) && (s <= 5)));
            tick;
            w = sb.pop_front();
            if (b_exp) pulses++;
            total++;
            if (obs_b !== w) begin bad++; $display("FAIL bcd k=%0d got=%h want=%h", k, obs_b, w); end
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL bcd_pulses got=%0d want=1", pulses); end
    endtask

    initial begin
        test_reset;
        test_countdown("countdown");
        test_expired_hold;
        act_a = 1'b0;
        tick;
        test_countdown("restart");
        test_abort;
        test_reset_midround;
        test_bcd;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
